// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: digit count, active-low
// 7-segment patterns {g,f,e,d,c,b,a} and the prescaler width helper.
package stopwatch_pkg;

  localparam int DIGIT_COUNT = 4;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // Width of a counter running 0..div-1; never narrower than one bit.
  function automatic int prescale_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// BCD nibble to active-low 7-segment pattern; non-decimal nibbles show a dash.
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display_mux.sv
// Time-multiplexed 4-digit common-anode driver. One frame samples the BCD bus
// once, then shows each digit for REFRESH_DIV cycles behind a short guard gap.
module stopwatch_display_mux
  import stopwatch_pkg::*;
#(
  parameter int         REFRESH_DIV  = 100000,
  parameter int         GUARD_CYCLES = 16,
  parameter logic [3:0] DP_MASK      = 4'b0100,
  parameter bit         BLANK_LEAD   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        display_en,
  input  logic [15:0] digits,
  output logic [6:0]  segments,
  output logic        dp,
  output logic [3:0]  anodes,
  output logic        frame_done
);

  localparam int            PW    = prescale_width(REFRESH_DIV);
  localparam int            SW    = $clog2(DIGIT_COUNT);
  localparam logic [PW-1:0] LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD = PW'(GUARD_CYCLES);
  localparam logic [SW-1:0] LAST_DIGIT = SW'(DIGIT_COUNT - 1);

  logic [PW-1:0] prescaler;
  logic [SW-1:0] select;
  logic [15:0]   snapshot;

  logic       slot_tick;
  logic       frame_start;
  logic       in_guard;
  logic       lead_blank;
  logic [3:0] nibble;
  logic [6:0] seg_dec;

  assign slot_tick   = (prescaler == LAST);
  assign frame_start = display_en && (prescaler == '0) && (select == '0);
  assign in_guard    = (prescaler < GUARD);
  assign nibble      = snapshot[{select, 2'b00} +: 4];
  // Leading zero suppression keeps the anode driven so dwell time stays uniform.
  assign lead_blank  = BLANK_LEAD && (select == LAST_DIGIT) && (nibble == 4'd0);

  bcd_to_seg u_dec (
    .bcd (nibble),
    .seg (seg_dec)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler  <= '0;
      select     <= '0;
      snapshot   <= 16'h0000;
      anodes     <= 4'b1111;
      segments   <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else if (!display_en) begin
      prescaler  <= '0;
      select     <= '0;
      anodes     <= 4'b1111;
      segments   <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      prescaler  <= slot_tick ? '0 : prescaler + 1'b1;
      select     <= slot_tick ? select + 1'b1 : select;
      frame_done <= slot_tick && (select == LAST_DIGIT);
      if (frame_start)
        snapshot <= digits;
      if (in_guard) begin
        anodes   <= 4'b1111;
        segments <= SEG_OFF;
        dp       <= 1'b1;
      end else begin
        anodes   <= ~(4'b0001 << select);
        segments <= lead_blank ? SEG_OFF : seg_dec;
        dp       <= lead_blank ? 1'b1 : ~DP_MASK[select];
      end
    end
  end

endmodule
